// File: rtl/bpsk_demod.sv
// Integrate-and-dump BPSK detector: hard bit decisions packed MSB-first into n-bit codewords.
// Optional differential decoding is enabled by defining BPSK_DIFF_EN.
module bpsk_demod #(
    parameter int n   = 7,
    parameter int SW  = 8,
    parameter int SPS = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic [SW-1:0] SampleIn,
    input  logic          SampleValid,
    input  logic          Sync,
    input  logic          Flag,
    output logic          BitOut,
    output logic          BitValid,
    output logic [n-1:0]  DataOut,
    output logic          DataValid
);

    localparam int AW = SW + $clog2(SPS) + 1;
    localparam int CW = $clog2(SPS);
    localparam int BW = $clog2(n);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sx;
    logic signed [AW-1:0] sum;
    logic [CW-1:0]        scnt;
    logic [BW-1:0]        bcnt;
    logic [n-2:0]         shreg;
    logic                 raw;
    logic                 dbit;
    logic                 dump;

    always_comb begin
        sx   = AW'($signed(SampleIn));
        sum  = acc + sx;
        raw  = sum[AW-1];
        dump = SampleValid && (scnt == CW'(SPS - 1));
    end

`ifdef BPSK_DIFF_EN
    logic prev_raw;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            prev_raw <= 1'b0;
        else if (Sync)
            prev_raw <= 1'b0;
        else if (dump)
            prev_raw <= raw;
    end

    assign dbit = raw ^ prev_raw;
`else
    assign dbit = raw;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            acc       <= '0;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            BitOut    <= 1'b0;
            BitValid  <= 1'b0;
            DataOut   <= '0;
            DataValid <= 1'b0;
        end else begin
            BitValid  <= 1'b0;
            DataValid <= 1'b0;
            if (Sync) begin
                // A sample arriving with Sync is sample 0 of the new bit
                acc   <= SampleValid ? sx : '0;
                scnt  <= SampleValid ? CW'(1) : '0;
                bcnt  <= '0;
                shreg <= '0;
            end else if (dump) begin
                acc      <= '0;
                scnt     <= '0;
                BitOut   <= dbit;
                BitValid <= 1'b1;
                shreg    <= {shreg[n-3:0], dbit};
                if (bcnt == BW'(n - 1)) begin
                    DataOut   <= {shreg, dbit} ^ {n{Flag}};
                    DataValid <= 1'b1;
                    bcnt      <= '0;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end else if (SampleValid) begin
                acc  <= sum;
                scnt <= scnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bpsk_demod.sv
// Self-checking bench for bpsk_demod: directed scenarios plus random traffic
// compared against a queue-based behavioural model of the detector.
module tb_bpsk_demod;

    localparam int N   = 7;
    localparam int SW  = 8;
    localparam int SPS = 4;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic [SW-1:0] SampleIn = '0;
    logic          SampleValid = 1'b0;
    logic          Sync = 1'b0;
    logic          Flag = 1'b0;
    logic          BitOut;
    logic          BitValid;
    logic [N-1:0]  DataOut;
    logic          DataValid;

    int errors = 0;
    int checks = 0;

    // model state
    int       m_sum;
    int       m_cnt;
    int       m_bits[$];
    logic     m_prev;
    logic     e_bo;
    logic     e_bv;
    logic [N-1:0] e_do;
    logic     e_dv;

    bpsk_demod #(.n(N), .SW(SW), .SPS(SPS)) dut (
        .CLK(CLK), .RSTn(RSTn), .SampleIn(SampleIn), .SampleValid(SampleValid),
        .Sync(Sync), .Flag(Flag), .BitOut(BitOut), .BitValid(BitValid),
        .DataOut(DataOut), .DataValid(DataValid)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum = 0; m_cnt = 0; m_bits.delete(); m_prev = 1'b0;
        e_bo = 1'b0; e_bv = 1'b0; e_do = '0; e_dv = 1'b0;
    endtask

    task automatic model_step(input logic v, input int s, input logic sy, input logic fl);
        logic r, b;
        logic [N-1:0] w;
        e_bv = 1'b0;
        e_dv = 1'b0;
        if (sy) begin
            m_sum = v ? s : 0;
            m_cnt = v ? 1 : 0;
            m_bits.delete();
            m_prev = 1'b0;
        end else if (v) begin
            m_sum += s;
            m_cnt++;
            if (m_cnt == SPS) begin
                r = (m_sum < 0);
`ifdef BPSK_DIFF_EN
                b = r ^ m_prev;
`else
                b = r;
`endif
                m_prev = r;
                m_bits.push_back(int'(b));
                e_bo = b;
                e_bv = 1'b1;
                if (m_bits.size() == N) begin
                    w = '0;
                    foreach (m_bits[i]) w = {w[N-2:0], m_bits[i][0]};
                    e_do = fl ? ~w : w;
                    e_dv = 1'b1;
                    m_bits.delete();
                end
                m_sum = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input logic v, input int s, input logic sy, input logic fl);
        @(negedge CLK);
        SampleValid = v;
        SampleIn    = SW'(s);
        Sync        = sy;
        Flag        = fl;
        @(posedge CLK);
        #1;
        model_step(v, s, sy, fl);
        chk("BitValid", 32'(BitValid), 32'(e_bv));
        chk("DataValid", 32'(DataValid), 32'(e_dv));
        chk("BitOut", 32'(BitOut), 32'(e_bo));
        chk("DataOut", 32'(DataOut), 32'(e_do));
    endtask

    task automatic send_bit(input logic b, input logic fl);
        for (int k = 0; k < SPS; k++) step(1'b1, b ? -100 : 100, 1'b0, fl);
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic fl);
        logic [N-1:0] t;
        t = w;
        for (int k = N - 1; k >= 0; k--) send_bit(t[k], fl);
    endtask

    initial begin
        logic [7:0] r8;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_BitOut", 32'(BitOut), 0);
        chk("rst_BitValid", 32'(BitValid), 0);
        chk("rst_DataOut", 32'(DataOut), 0);
        chk("rst_DataValid", 32'(DataValid), 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // decisions: strong negative, then zero sum
        for (int k = 0; k < SPS; k++) step(1'b1, -3, 1'b0, 1'b0);
        chk("dec_neg_bit", 32'(BitOut), 1);
        chk("dec_neg_valid", 32'(BitValid), 1);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("dec_pulse_once", 32'(BitValid), 0);
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, -1, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, -1, 1'b0, 1'b0);
        chk("dec_zero_bit", 32'(BitOut), 0);

        // full words, plain and inverted
        step(1'b0, 0, 1'b1, 1'b0);
        send_word(7'b1011001, 1'b0);
        chk("word_dv", 32'(DataValid), 1);
`ifndef BPSK_DIFF_EN
        chk("word_f0", 32'(DataOut), 32'(7'b1011001));
`endif
        send_word(7'b1011001, 1'b1);
`ifndef BPSK_DIFF_EN
        chk("word_f1", 32'(DataOut), 32'(7'b0100110));
`endif

        // gapped full-scale negative bit: sum -512
        for (int k = 0; k < SPS; k++) begin
            step(1'b1, -128, 1'b0, 1'b0);
            if (k != SPS - 1) step(1'b0, 0, 1'b0, 1'b0);
        end
        chk("gap_bit", 32'(BitValid), 1);
        for (int k = 0; k < SPS; k++) step(1'b1, 127, 1'b0, 1'b0);

        // Sync after 3 bits, then 7 ones
        step(1'b0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        send_word(7'h7F, 1'b0);
`ifndef BPSK_DIFF_EN
        chk("sync_word", 32'(DataOut), 32'h7F);
`endif

        // Sync on a dump cycle suppresses the bit
        for (int k = 0; k < SPS - 1; k++) step(1'b1, -50, 1'b0, 1'b0);
        step(1'b1, -50, 1'b1, 1'b0);
        chk("sync_dump_nobit", 32'(BitValid), 0);
        for (int k = 0; k < SPS - 1; k++) step(1'b1, 60, 1'b0, 1'b0);

`ifdef BPSK_DIFF_EN
        step(1'b0, 0, 1'b1, 1'b0);
        send_word(7'b1100101, 1'b0);
        chk("diff_word", 32'(DataOut), 32'(7'b1010111));
`endif

        // reset mid-accumulation
        step(1'b1, -90, 1'b0, 1'b0);
        step(1'b1, -90, 1'b0, 1'b0);
        @(negedge CLK);
        SampleValid = 1'b0;
        RSTn = 1'b0;
        #1;
        chk("midrst_BitOut", 32'(BitOut), 0);
        chk("midrst_DataOut", 32'(DataOut), 0);
        chk("midrst_BitValid", 32'(BitValid), 0);
        chk("midrst_DataValid", 32'(DataValid), 0);
        @(negedge CLK);
        RSTn = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < SPS; k++) step(1'b1, 40, 1'b0, 1'b0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            r8 = 8'($urandom);
            step($urandom_range(0, 3) != 0, int'($signed(r8)),
                 $urandom_range(0, 59) == 0, 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
